// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC timebase: FSM states, output mode encoding and
// the default terminal count for a 100 MHz system clock.
package rtc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } rtc_state_e;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned DEF_MAX_100MHZ = 500000;

endpackage

// File: rtl/rtc_tick_counter.sv
// Wrapping elapsed-tick counter with count enable and synchronous clear.
module rtc_tick_counter #(
    parameter int unsigned TICK_W = 16
) (
    input  logic              i_sclk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_enb,
    output logic [TICK_W-1:0] o_count
);

    logic [TICK_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enb) begin
            count_d = count_q + TICK_W'(1);
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/rtc_timebase_gen.sv
// Programmable RTC period generator: counts 1..act_max, emits a tick per rollover
// and supports deferred (shadowed) reloads of the terminal count while running.
module rtc_timebase_gen
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_W   = 19,
    parameter int unsigned DEF_MAX = DEF_MAX_100MHZ,
    parameter int unsigned TICK_W  = 16
) (
    input  logic              i_sclk,
    input  logic              i_reset_n,
    input  logic              i_timerenb,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [CNT_W-1:0]  i_max_count,
    input  logic              i_mode,
    output logic              o_basetick,
    output logic              o_tickpulse,
    output logic [CNT_W-1:0]  o_count,
    output logic [TICK_W-1:0] o_tickcnt,
    output logic              o_loaderr
);

    rtc_state_e state_q, state_d;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_max_q, act_max_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             basetick_q, basetick_d;
    logic             tickpulse_q, tickpulse_d;
    logic             loaderr_q, loaderr_d;
    logic             mode_q;
    logic             run, rollover, load_ok;

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_timerenb)  state_d = StRun;
            StRun:   if (!i_timerenb) state_d = StHold;
            StHold:  if (i_timerenb)  state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (i_clear) state_d = StIdle;
    end

    // Counting follows the state being entered, so enabling from IDLE counts on the
    // same edge. ">=" guards against a counter left above a max loaded while held.
    assign run      = (state_d == StRun);
    assign rollover = run && (count_q >= act_max_q);
    assign load_ok  = i_load && (i_max_count >= CNT_W'(2));

    always_comb begin
        count_d     = count_q;
        act_max_d   = act_max_q;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        basetick_d  = basetick_q;
        tickpulse_d = rollover;
        loaderr_d   = i_load && !load_ok;

        if (load_ok) shadow_d = i_max_count;

        if (i_clear) begin
            count_d    = CNT_W'(1);
            basetick_d = 1'b0;
            pend_d     = 1'b0;
            if (load_ok)     act_max_d = i_max_count;
            else if (pend_q) act_max_d = shadow_q;
        end else if (run) begin
            if (rollover) begin
                count_d = CNT_W'(1);
                pend_d  = 1'b0;
                if (load_ok)     act_max_d = i_max_count;
                else if (pend_q) act_max_d = shadow_q;
            end else begin
                count_d = count_q + CNT_W'(1);
                if (load_ok) pend_d = 1'b1;
            end
        end else if (load_ok) begin
            act_max_d = i_max_count;
            pend_d    = 1'b0;
        end

        if (!i_clear) begin
            if (i_mode != mode_q) begin
                basetick_d = 1'b0;
            end else if (mode_q == MODE_PULSE) begin
                basetick_d = rollover;
            end else if (rollover) begin
                basetick_d = ~basetick_q;
            end
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q     <= CNT_W'(1);
            act_max_q   <= CNT_W'(DEF_MAX);
            shadow_q    <= CNT_W'(DEF_MAX);
            pend_q      <= 1'b0;
            basetick_q  <= 1'b0;
            tickpulse_q <= 1'b0;
            loaderr_q   <= 1'b0;
            mode_q      <= MODE_TOGGLE;
        end else begin
            count_q     <= count_d;
            act_max_q   <= act_max_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            basetick_q  <= basetick_d;
            tickpulse_q <= tickpulse_d;
            loaderr_q   <= loaderr_d;
            mode_q      <= i_mode;
        end
    end

    rtc_tick_counter #(
        .TICK_W (TICK_W)
    ) u_tick_counter (
        .i_sclk    (i_sclk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_clear),
        .i_enb     (rollover),
        .o_count   (o_tickcnt)
    );

    assign o_basetick  = basetick_q;
    assign o_tickpulse = tickpulse_q;
    assign o_count     = count_q;
    assign o_loaderr   = loaderr_q;

endmodule

// File: tb/tb_rtc_timebase_gen.sv
// Directed bench for rtc_timebase_gen with a 5-cycle default period and 4-bit tick count.
module tb_rtc_timebase_gen;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TICK_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              timerenb, clear, load, mode;
    logic [CNT_W-1:0]  max_count;
    logic              basetick, tickpulse, loaderr;
    logic [CNT_W-1:0]  count;
    logic [TICK_W-1:0] tickcnt;

    int total = 0;
    int bad   = 0;
    int highs, pat_err;

    always #5 clk = ~clk;

    rtc_timebase_gen #(
        .CNT_W   (CNT_W),
        .DEF_MAX (5),
        .TICK_W  (TICK_W)
    ) dut (
        .i_sclk      (clk),
        .i_reset_n   (rst_n),
        .i_timerenb  (timerenb),
        .i_clear     (clear),
        .i_load      (load),
        .i_max_count (max_count),
        .i_mode      (mode),
        .o_basetick  (basetick),
        .o_tickpulse (tickpulse),
        .o_count     (count),
        .o_tickcnt   (tickcnt),
        .o_loaderr   (loaderr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; timerenb = 1'b0; clear = 1'b0; load = 1'b0; mode = 1'b0;
        max_count = '0;
        step(2);
        check_eq("rst_count", count, 1);
        check_eq("rst_loaderr", loaderr, 0);
        rst_n = 1'b1;
        step(1);
        check_eq("init_count", count, 1);
        check_eq("init_basetick", basetick, 0);
        check_eq("init_tickcnt", tickcnt, 0);

        // Toggle mode: 5-cycle period
        timerenb = 1'b1;
        step(1);
        check_eq("first_count", count, 2);
        step(3);
        check_eq("pre_roll_count", count, 5);
        check_eq("pre_roll_base", basetick, 0);
        step(1);
        check_eq("roll1_base", basetick, 1);
        check_eq("roll1_pulse", tickpulse, 1);
        check_eq("roll1_count", count, 1);
        check_eq("roll1_tickcnt", tickcnt, 1);
        step(1);
        check_eq("roll1_pulse_end", tickpulse, 0);
        step(4);
        check_eq("roll2_base", basetick, 0);
        check_eq("roll2_pulse", tickpulse, 1);
        check_eq("roll2_tickcnt", tickcnt, 2);

        // Deferred load of 8 at count 3
        step(2);
        check_eq("defer_at3", count, 3);
        load = 1'b1; max_count = 8'd8;
        step(1);
        load = 1'b0;
        check_eq("defer_count4", count, 4);
        step(1);
        check_eq("defer_count5", count, 5);
        step(1);
        check_eq("defer_old_roll_cnt", count, 1);
        check_eq("defer_old_roll_pulse", tickpulse, 1);
        step(7);
        check_eq("defer_reach8", count, 8);
        check_eq("defer_no_early", tickpulse, 0);
        step(1);
        check_eq("defer_new_roll_cnt", count, 1);
        check_eq("defer_new_roll_pulse", tickpulse, 1);

        // Clear with simultaneous load restores a period of 5
        clear = 1'b1; load = 1'b1; max_count = 8'd5;
        step(1);
        clear = 1'b0;
        check_eq("clrld_count", count, 1);
        check_eq("clrld_tickcnt", tickcnt, 0);
        check_eq("clrld_base", basetick, 0);
        max_count = 8'd1;
        step(1);
        load = 1'b0;
        check_eq("rej_loaderr", loaderr, 1);
        check_eq("rej_count", count, 2);
        step(1);
        check_eq("rej_loaderr_end", loaderr, 0);
        step(2);
        check_eq("rej_count5", count, 5);
        step(1);
        check_eq("rej_roll_cnt", count, 1);
        check_eq("rej_roll_pulse", tickpulse, 1);

        // Hold at count 4 for 20 cycles
        step(3);
        timerenb = 1'b0;
        step(10);
        check_eq("hold_mid", count, 4);
        step(10);
        check_eq("hold_end", count, 4);
        check_eq("hold_tickcnt", tickcnt, 1);
        timerenb = 1'b1;
        step(1);
        check_eq("resume_count", count, 5);
        step(1);
        check_eq("resume_roll_cnt", count, 1);
        check_eq("resume_roll_pulse", tickpulse, 1);
        check_eq("resume_tickcnt", tickcnt, 2);

        // Pulse mode across 16 periods, tick counter wraps
        clear = 1'b1; mode = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("pm_clr_tickcnt", tickcnt, 0);
        highs = 0; pat_err = 0;
        for (int p = 0; p < 16; p++) begin
            for (int c = 0; c < 5; c++) begin
                step(1);
                if (basetick) highs++;
                if (c == 4) begin
                    if (basetick !== 1'b1 || tickpulse !== 1'b1 || count !== 8'd1) pat_err++;
                end else begin
                    if (basetick !== 1'b0 || count !== 8'(c + 2)) pat_err++;
                end
            end
            if (p == 14) check_eq("pm_tickcnt15", tickcnt, 15);
        end
        check_eq("pm_highs", highs, 16);
        check_eq("pm_pattern_errs", pat_err, 0);
        check_eq("pm_wrap", tickcnt, 0);

        // Clear on the rollover cycle wins
        step(5);
        check_eq("cp_pre_tickcnt", tickcnt, 1);
        step(4);
        check_eq("cp_pre_count", count, 5);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("cp_pulse", tickpulse, 0);
        check_eq("cp_count", count, 1);
        check_eq("cp_tickcnt", tickcnt, 0);

        // Asynchronous reset mid-period discards state and pending load
        mode = 1'b0;
        step(7);
        check_eq("ar_pre_count", count, 3);
        check_eq("ar_pre_base", basetick, 1);
        check_eq("ar_pre_tickcnt", tickcnt, 1);
        load = 1'b1; max_count = 8'd9;
        step(1);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_count", count, 1);
        check_eq("ar_base", basetick, 0);
        check_eq("ar_tickcnt", tickcnt, 0);
        check_eq("ar_pulse", tickpulse, 0);
        step(1);
        rst_n = 1'b1;
        step(4);
        check_eq("ar_after_count5", count, 5);
        step(1);
        check_eq("ar_after_roll", tickpulse, 1);
        check_eq("ar_after_count1", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
